// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard FIFO consumer, scan-code parser, key tracker; ASCII lookup under PS2_KBD_ASCII_EN
module ps2_kbd_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_held,
  output logic [CNT_W-1:0] key_count,
  output logic             ovf_sticky,
  output logic [7:0]       key_ascii
);
  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] byte_q, byte_d, code_q, code_d, hcode_q, hcode_d;
  logic ext_q, ext_d, brk_q, brk_d, kv_q, kv_d, kext_q, kext_d, kbrk_q, kbrk_d;
  logic held_q, held_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_pop, is_e0, is_f0, ev, new_press;
  // Pop sequencer: one byte per IDLE->POP->WAIT round, pop strobe only in POP
  always_comb begin
    state_d = state_q == IDLE ? (ready ? POP : IDLE) : state_q == POP ? WAIT : IDLE;
    nextdata_n = state_q != POP;
  end
  // Byte parser and key tracker: prefixes accumulate, any other byte emits an event
  always_comb begin
    is_pop = state_q == POP;
    is_e0 = byte_q == 8'hE0;
    is_f0 = byte_q == 8'hF0;
    ev = is_pop && !is_e0 && !is_f0;
    new_press = ev && !brk_q && (!held_q || byte_q != hcode_q);
    byte_d = (state_q == IDLE && ready) ? data : byte_q;
    ext_d = ev ? 1'b0 : (is_pop && is_e0) ? 1'b1 : ext_q;
    brk_d = ev ? 1'b0 : (is_pop && is_f0) ? 1'b1 : brk_q;
    kv_d = ev;
    code_d = ev ? byte_q : code_q;
    kext_d = ev ? ext_q : kext_q;
    kbrk_d = ev ? brk_q : kbrk_q;
    held_d = new_press ? 1'b1 : (ev && brk_q && byte_q == hcode_q) ? 1'b0 : held_q;
    hcode_d = new_press ? byte_q : hcode_q;
    cnt_d = cnt_q + CNT_W'(new_press);
    ovf_d = ovf_q | overflow;
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      byte_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      kv_q <= 1'b0;
      code_q <= '0;
      kext_q <= 1'b0;
      kbrk_q <= 1'b0;
      held_q <= 1'b0;
      hcode_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      kv_q <= kv_d;
      code_q <= code_d;
      kext_q <= kext_d;
      kbrk_q <= kbrk_d;
      held_q <= held_d;
      hcode_q <= hcode_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign key_valid = kv_q;
  assign key_code = code_q;
  assign key_ext = kext_q;
  assign key_break = kbrk_q;
  assign key_held = held_q;
  assign key_count = cnt_q;
  assign ovf_sticky = ovf_q;
`ifdef PS2_KBD_ASCII_EN
  logic [7:0] asc;
  // Scan-code set 2 to ASCII for letters, digits, space and enter
  always_comb begin
    case (code_q)
      8'h1C: asc = 8'h61; 8'h32: asc = 8'h62; 8'h21: asc = 8'h63; 8'h23: asc = 8'h64;
      8'h24: asc = 8'h65; 8'h2B: asc = 8'h66; 8'h34: asc = 8'h67; 8'h33: asc = 8'h68;
      8'h43: asc = 8'h69; 8'h3B: asc = 8'h6A; 8'h42: asc = 8'h6B; 8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D; 8'h31: asc = 8'h6E; 8'h44: asc = 8'h6F; 8'h4D: asc = 8'h70;
      8'h15: asc = 8'h71; 8'h2D: asc = 8'h72; 8'h1B: asc = 8'h73; 8'h2C: asc = 8'h74;
      8'h3C: asc = 8'h75; 8'h2A: asc = 8'h76; 8'h1D: asc = 8'h77; 8'h22: asc = 8'h78;
      8'h35: asc = 8'h79; 8'h1A: asc = 8'h7A;
      8'h45: asc = 8'h30; 8'h16: asc = 8'h31; 8'h1E: asc = 8'h32; 8'h26: asc = 8'h33;
      8'h25: asc = 8'h34; 8'h2E: asc = 8'h35; 8'h36: asc = 8'h36; 8'h3D: asc = 8'h37;
      8'h3E: asc = 8'h38; 8'h46: asc = 8'h39;
      8'h29: asc = 8'h20; 8'h5A: asc = 8'h0D;
      default: asc = 8'h00;
    endcase
  end
  assign key_ascii = kext_q ? 8'h00 : asc;
`else
  assign key_ascii = 8'h00;
`endif
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;
`ifdef PS2_KBD_ASCII_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif
  logic clk = 1'b0, clrn = 1'b0, ready = 1'b0, overflow = 1'b0;
  logic [7:0] data = 8'h00;
  logic nextdata_n, key_valid, key_ext, key_break, key_held, ovf_sticky;
  logic [7:0] key_code, key_count, key_ascii;
  int total = 0, bad = 0, cyc = 0, pops = 0, kvs = 0, last_pop = -100, min_gap = 1000, dbl_pop = 0, long_kv = 0;
  int s_kv, s_pop;
  logic prev_ndn = 1'b1, prev_kv = 1'b0;
  logic [7:0] codes [7] = '{8'h1C, 8'h45, 8'h29, 8'h5A, 8'h76, 8'h1A, 8'h46};
  logic [7:0] ascs  [7] = '{8'h61, 8'h30, 8'h20, 8'h0D, 8'h00, 8'h7A, 8'h39};

  ps2_kbd_ctrl dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_held(key_held),
    .key_count(key_count), .ovf_sticky(ovf_sticky), .key_ascii(key_ascii)
  );

  always #5 clk = ~clk;

  // Pop spacing and pulse-width monitor
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!nextdata_n) begin
      pops <= pops + 1;
      if (cyc - last_pop < min_gap) min_gap <= cyc - last_pop;
      last_pop <= cyc;
      if (!prev_ndn) dbl_pop <= dbl_pop + 1;
    end
    if (key_valid) begin
      kvs <= kvs + 1;
      if (prev_kv) long_kv <= long_kv + 1;
    end
    prev_ndn <= nextdata_n;
    prev_kv <= key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic feed(input logic [7:0] b);
    int n = 0;
    data = b;
    ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (nextdata_n && n < 20);
    if (nextdata_n) chk("pop_timeout", nextdata_n, 0);
    ready = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ndn"}, nextdata_n, 1);
    chk({tag, "_kv"}, key_valid, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_ext"}, key_ext, 0);
    chk({tag, "_brk"}, key_break, 0);
    chk({tag, "_held"}, key_held, 0);
    chk({tag, "_cnt"}, key_count, 0);
    chk({tag, "_ovf"}, ovf_sticky, 0);
    chk({tag, "_asc"}, key_ascii, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ndn", nextdata_n, 1);
    // single make 1C
    s_pop = pops;
    feed(8'h1C);
    @(negedge clk);
    chk("t1_kv_pulse", key_valid, 1);
    @(negedge clk);
    chk("t1_kv_end", key_valid, 0);
    chk("t1_pops", pops - s_pop, 1);
    chk("t1_code", key_code, 8'h1C);
    chk("t1_ext", key_ext, 0);
    chk("t1_brk", key_break, 0);
    chk("t1_held", key_held, 1);
    chk("t1_cnt", key_count, 1);
    chk("t1_asc", key_ascii, AEN ? 8'h61 : 8'h00);
    // typematic repeat then release
    do_reset();
    s_kv = kvs;
    feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
    settle();
    chk("t2_kvs", kvs - s_kv, 4);
    chk("t2_cnt", key_count, 1);
    chk("t2_brk", key_break, 1);
    chk("t2_held", key_held, 0);
    chk("t2_code", key_code, 8'h1C);
    // extended release
    s_kv = kvs;
    s_pop = pops;
    feed(8'hE0); feed(8'hF0); feed(8'h75);
    settle();
    chk("t3_kvs", kvs - s_kv, 1);
    chk("t3_pops", pops - s_pop, 3);
    chk("t3_code", key_code, 8'h75);
    chk("t3_ext", key_ext, 1);
    chk("t3_brk", key_break, 1);
    chk("t3_cnt", key_count, 1);
    // reversed prefix order
    feed(8'hF0); feed(8'hE0); feed(8'h6B);
    settle();
    chk("t3b_code", key_code, 8'h6B);
    chk("t3b_ext", key_ext, 1);
    chk("t3b_brk", key_break, 1);
    // non-matching break leaves held
    feed(8'h1B); feed(8'hF0); feed(8'h1C);
    settle();
    chk("t3c_held", key_held, 1);
    chk("t3c_cnt", key_count, 2);
    // counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin
      feed(8'h16); feed(8'hF0); feed(8'h16);
    end
    settle();
    chk("t4_cnt_ff", key_count, 8'hFF);
    chk("t4_held", key_held, 0);
    feed(8'h16);
    settle();
    chk("t4_held_on", key_held, 1);
    feed(8'hF0); feed(8'h16);
    settle();
    chk("t4_cnt_wrap", key_count, 8'h00);
    // reset in WAIT after F0
    feed(8'h1C);
    feed(8'hF0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk_reset("t5_rst");
    repeat (2) @(negedge clk);
    chk("t5_ndn_hold", nextdata_n, 1);
    clrn = 1'b1;
    @(negedge clk);
    feed(8'h1C);
    settle();
    chk("t5_code", key_code, 8'h1C);
    chk("t5_brk", key_break, 0);
    chk("t5_held", key_held, 1);
    chk("t5_cnt", key_count, 1);
    // overflow sticky
    chk("t6_ovf0", ovf_sticky, 0);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    @(negedge clk);
    chk("t6_ovf1", ovf_sticky, 1);
    repeat (5) @(negedge clk);
    chk("t6_ovf_hold", ovf_sticky, 1);
    clrn = 1'b0;
    #1;
    chk("t6_ovf_clr", ovf_sticky, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    // ASCII lookup
    for (int i = 0; i < 7; i++) begin
      feed(codes[i]);
      settle();
      chk("t7_code", key_code, codes[i]);
      chk("t7_asc", key_ascii, AEN ? ascs[i] : 8'h00);
    end
    feed(8'hE0); feed(8'h1C);
    settle();
    chk("t7_ext_code", key_code, 8'h1C);
    chk("t7_ext_asc", key_ascii, 8'h00);
    // global pop spacing
    chk("min_gap_ge3", min_gap >= 3, 1);
    chk("dbl_pop", dbl_pop, 0);
    chk("long_kv", long_kv, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the key-press counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ready  input  1  keyboard FIFO non-empty; data valid.
REQ-005 SHALL have port data  input  8  scan-code byte at FIFO head.
REQ-006 SHALL have port overflow  input  1  keyboard FIFO overflow flag.
REQ-007 SHALL have port nextdata_n  output  1  active-low pop strobe to keyboard FIFO.
REQ-008 SHALL have port key_valid  output  1  one-cycle key-event pulse.
REQ-009 SHALL have port key_code  output  8  scan code of the last event.
REQ-010 SHALL have port key_ext  output  1  last event was E0-prefixed.
REQ-011 SHALL have port key_break  output  1  last event was a release (F0-prefixed).
REQ-012 SHALL have port key_held  output  1  a key is currently held.
REQ-013 SHALL have port key_count  output  CNT_W  number of distinct presses.
REQ-014 SHALL have port ovf_sticky  output  1  overflow seen since reset.
REQ-015 SHALL have port key_ascii  output  8  ASCII of key_code (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE, POP, WAIT; IDLE->POP when ready=1; POP->WAIT unconditionally; WAIT->IDLE unconditionally.
REQ-017 SHALL capture data into an internal byte register on the IDLE->POP edge.
REQ-018 SHALL drive nextdata_n=0 exactly during POP (one cycle per byte) and 1 in all other states.
REQ-019 SHALL never issue two pops without an intervening WAIT cycle; max throughput one byte per 3 cycles.
REQ-020 SHALL, in POP, parse the captured byte: 0xE0 sets ext flag, 0xF0 sets brk flag, neither generates an event.
REQ-021 SHALL, for any other byte in POP, pulse key_valid=1 on the next cycle with key_code=byte, key_ext=ext flag, key_break=brk flag, then clear both flags.
REQ-022 SHALL hold key_code/key_ext/key_break stable between events.
REQ-023 SHALL, on a make event with key_held=0 or key_code differing from the held code, set key_held=1, record held code, increment key_count.
REQ-024 SHALL treat a make event equal to the held code while key_held=1 as typematic repeat: key_valid pulses, key_count unchanged.
REQ-025 SHALL, on a break event matching the held code, clear key_held; a non-matching break leaves key_held unchanged.
REQ-026 SHALL wrap key_count modulo 2^CNT_W (0xFF -> 0x00 for default).
REQ-027 SHALL set ovf_sticky when overflow=1 is sampled on any edge; cleared only by reset.
REQ-028 SHALL ignore the E0/F0 order: E0 F0 xx and F0 E0 xx both yield ext=1, break=1.

Reset
REQ-029 SHALL, while clrn=0, force state IDLE, nextdata_n=1, key_valid=0, key_code=0, key_ext=0, key_break=0, key_held=0, key_count=0, ovf_sticky=0, ext/brk flags=0, held code=0.
REQ-030 SHALL abandon any in-flight byte or prefix on reset mid-operation; first pop after release occurs no earlier than the first edge with ready=1.

Configuration
REQ-031 SHALL, with PS2_KBD_ASCII_EN defined, drive key_ascii combinationally from key_code per scan-code set 2: a-z lower case, 0-9, 0x29->0x20, 0x5A->0x0D; 0x00 for unmapped codes or key_ext=1.
REQ-032 SHALL, without PS2_KBD_ASCII_EN, tie key_ascii to 0x00 and contain no lookup table.

Verification
REQ-033 SHALL cover: FIFO bytes 1C -> one pop, key_valid pulse, key_code=0x1C, ext=0, break=0, key_held=1, key_count=1, key_ascii=0x61 (ASCII_EN).
REQ-034 SHALL cover: bytes 1C 1C 1C F0 1C -> 4 key_valid pulses, key_count=1, final key_break=1, key_held=0.
REQ-035 SHALL cover: bytes E0 F0 75 -> exactly one key_valid, key_code=0x75, ext=1, break=1; pops spaced >=3 cycles, nextdata_n low 1 cycle each.
REQ-036 SHALL cover: 256 press/release pairs of 0x16 -> key_count back to 0x00.
REQ-037 SHALL cover: clrn low during WAIT after byte F0, then byte 1C -> make event, break=0, all outputs reset-valued during clrn=0.
REQ-038 SHALL cover: overflow pulsed 1 cycle -> ovf_sticky=1 until clrn asserted.
